// File: rtl/gpu_core_pkg.sv
// Shared definitions for the gpu_core_p lane: FSM states, opcodes and
// instruction field positions.
package gpu_core_pkg;

  typedef enum logic [3:0] {
    S_LOAD, S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEMWAIT, S_WB, S_DONE
  } state_e;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_ADD   = 4'd1;
  localparam logic [3:0] OP_SUB   = 4'd2;
  localparam logic [3:0] OP_MUL   = 4'd3;
  localparam logic [3:0] OP_DIV   = 4'd4;
  localparam logic [3:0] OP_CMPGE = 4'd5;
  localparam logic [3:0] OP_SHR   = 4'd6;
  localparam logic [3:0] OP_SHL   = 4'd7;
  localparam logic [3:0] OP_AND   = 4'd8;
  localparam logic [3:0] OP_OR    = 4'd9;
  localparam logic [3:0] OP_XOR   = 4'd10;
  localparam logic [3:0] OP_LD    = 4'd11;
  localparam logic [3:0] OP_LI    = 4'd12;
  localparam logic [3:0] OP_ST    = 4'd13;
  localparam logic [3:0] OP_BNZ   = 4'd14;
  localparam logic [3:0] OP_HALT  = 4'd15;

  localparam int OP_MSB  = 15;
  localparam int OP_LSB  = 12;
  localparam int RA_MSB  = 11;
  localparam int RA_LSB  = 8;
  localparam int RB_MSB  = 7;
  localparam int RB_LSB  = 4;
  localparam int RD_MSB  = 3;
  localparam int RD_LSB  = 0;
  localparam int IMM_MSB = 11;
  localparam int IMM_LSB = 4;
  localparam int TGT_MSB = 7;
  localparam int TGT_LSB = 0;

  function automatic logic writes_rd(input logic [3:0] op);
    return (op >= OP_ADD && op <= OP_XOR) || op == OP_LI || op == OP_LD;
  endfunction

endpackage

// File: rtl/gpu_alu.sv
// Combinational ALU for the register-register opcodes.
module gpu_alu
  import gpu_core_pkg::*;
#(
  parameter int DATA_W = 8
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic [DATA_W-1:0] result
);

  logic sh_ovf;
  assign sh_ovf = 32'(b) >= DATA_W;

  always_comb begin
    result = '0;
    case (op)
      OP_NOP:   result = '0;
      OP_ADD:   result = a + b;
      OP_SUB:   result = a - b;
      OP_MUL:   result = a * b;
      OP_DIV:   result = (b == '0) ? '1 : a / b;
      OP_CMPGE: result = DATA_W'(a >= b);
      OP_SHR:   result = sh_ovf ? '0 : a >> b;
      OP_SHL:   result = sh_ovf ? '0 : a << b;
      OP_AND:   result = a & b;
      OP_OR:    result = a | b;
      OP_XOR:   result = a ^ b;
      default:  result = '0;
    endcase
  end

endmodule

// File: rtl/gpu_core_p.sv
// Single-lane multi-cycle core: streamed program load, 5-stage sequencing,
// blocking load/store handshake to shared memory.
module gpu_core_p
  import gpu_core_pkg::*;
#(
  parameter int DATA_W     = 8,
  parameter int IMEM_DEPTH = 16,
  parameter int ADDR_W     = 12
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              prog_valid,
  output logic              prog_ready,
  input  logic [15:0]       prog_data,
  input  logic              prog_last,
  input  logic              start,
  input  logic [3:0]        core_id,
  output logic              busy,
  output logic              done,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int IW = $clog2(IMEM_DEPTH);

  logic [15:0] imem [IMEM_DEPTH];

  state_e            state_q, state_d;
  logic [IW-1:0]     wptr_q, wptr_d, pc_q, pc_d, widx;
  logic [IW:0]       len_q, len_d;
  logic [15:0]       ir_q, ir_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d, st_q, st_d, res_q, res_d, alu_res;
  logic [DATA_W-1:0] regs_q [16];
  logic [DATA_W-1:0] regs_d [16];
  logic              mem_req_q, mem_req_d, mem_we_q, mem_we_d, pv_q;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
  logic [3:0]        op;
  logic [7:0]        tgt;
  logic              load_acc, taken, fin, is_mem;

  gpu_alu #(.DATA_W(DATA_W)) u_alu (.op(op), .a(a_q), .b(b_q), .result(alu_res));

  assign op     = ir_q[OP_MSB:OP_LSB];
  assign tgt    = ir_q[TGT_MSB:TGT_LSB];
  assign is_mem = (op == OP_LD) || (op == OP_ST);
  assign taken  = (op == OP_BNZ) && (a_q != '0);
  assign fin    = (op == OP_HALT)
               || (!taken && ((IW+1)'(pc_q) + (IW+1)'(1)) == len_q)
               || (taken && 32'(tgt) >= 32'(len_q));

  // In IDLE only a fresh prog_valid (rising) restarts loading, so the tail of
  // a burst that already filled the memory is dropped instead of reloaded.
  assign load_acc = prog_valid && (state_q == S_LOAD || (state_q == S_IDLE && !pv_q));
  assign widx     = (state_q == S_IDLE) ? '0 : wptr_q;

  assign prog_ready = (state_q == S_LOAD) || (state_q == S_IDLE);
  assign done       = (state_q == S_DONE);
  assign busy       = (state_q inside {S_FETCH, S_DECODE, S_EXEC, S_MEM, S_MEMWAIT, S_WB})
                   || (state_q == S_IDLE && start && !load_acc);
  assign mem_req    = mem_req_q;
  assign mem_we     = mem_we_q;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;

  always_comb begin
    state_d     = state_q;
    wptr_d      = wptr_q;
    len_d       = len_q;
    pc_d        = pc_q;
    ir_d        = ir_q;
    a_d         = a_q;
    b_d         = b_q;
    st_d        = st_q;
    res_d       = res_q;
    mem_req_d   = mem_req_q;
    mem_we_d    = mem_we_q;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
    regs_d      = regs_q;
    case (state_q)
      S_LOAD, S_IDLE: begin
        if (load_acc) begin
          if (prog_last || widx == IW'(IMEM_DEPTH - 1)) begin
            len_d   = (IW+1)'(widx) + (IW+1)'(1);
            wptr_d  = '0;
            state_d = S_IDLE;
          end else begin
            wptr_d  = widx + IW'(1);
            state_d = S_LOAD;
          end
        end else if (state_q == S_IDLE && start) begin
          pc_d       = '0;
          regs_d[15] = DATA_W'(core_id);
          state_d    = S_FETCH;
        end
      end
      S_FETCH: begin
        ir_d    = imem[pc_q];
        state_d = S_DECODE;
      end
      S_DECODE: begin
        a_d     = regs_q[ir_q[RA_MSB:RA_LSB]];
        b_d     = regs_q[ir_q[RB_MSB:RB_LSB]];
        st_d    = regs_q[ir_q[RD_MSB:RD_LSB]];
        state_d = S_EXEC;
      end
      S_EXEC: begin
        res_d = (op == OP_LI) ? DATA_W'(ir_q[IMM_MSB:IMM_LSB]) : alu_res;
        if (is_mem) begin
          mem_req_d   = 1'b1;
          mem_we_d    = (op == OP_ST);
          mem_addr_d  = ADDR_W'({a_q, b_q});
          mem_wdata_d = st_q;
        end
        state_d = S_MEM;
      end
      S_MEM, S_MEMWAIT: begin
        if (!mem_req_q) begin
          state_d = S_WB;
        end else if (mem_ack) begin
          if (op == OP_LD) res_d = mem_rdata;
          mem_req_d = 1'b0;
          mem_we_d  = 1'b0;
          state_d   = S_WB;
        end else begin
          state_d = S_MEMWAIT;
        end
      end
      S_WB: begin
        if (writes_rd(op)) regs_d[ir_q[RD_MSB:RD_LSB]] = res_q;
        pc_d    = taken ? IW'(tgt) : pc_q + IW'(1);
        state_d = fin ? S_DONE : S_FETCH;
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_LOAD;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= S_LOAD;
      wptr_q      <= '0;
      len_q       <= '0;
      pc_q        <= '0;
      ir_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      st_q        <= '0;
      res_q       <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      pv_q        <= 1'b0;
      for (int i = 0; i < 16; i++) regs_q[i] <= '0;
    end else begin
      state_q     <= state_d;
      wptr_q      <= wptr_d;
      len_q       <= len_d;
      pc_q        <= pc_d;
      ir_q        <= ir_d;
      a_q         <= a_d;
      b_q         <= b_d;
      st_q        <= st_d;
      res_q       <= res_d;
      mem_req_q   <= mem_req_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      pv_q        <= prog_valid;
      regs_q      <= regs_d;
    end
  end

  // Program memory keeps its contents through reset.
  always_ff @(posedge clk) begin
    if (!reset && load_acc) imem[widx] <= prog_data;
  end

endmodule

// File: doc/gpu_core_p.md
GPU_CORE_P -- requirements
Module: gpu_core_p

Interface
REQ-001 SHALL have parameter DATA_W, default 8, datapath and register width (4..32).
REQ-002 SHALL have parameter IMEM_DEPTH, default 16, instruction memory words (2..256, power of two).
REQ-003 SHALL have parameter ADDR_W, default 12, shared-memory address width.
REQ-004 SHALL have ports clk (input, 1, clock) and reset (input, 1, reset). Reset is synchronous and active-high; the clock is clk.
REQ-005 SHALL have ports prog_valid in 1 (program word offered), prog_ready out 1 (load accepted), prog_data in 16 (instruction word), prog_last in 1 (final word).
REQ-006 SHALL have ports start in 1 (begin execution), core_id in 4 (lane id), busy out 1 (executing), done out 1 (one-cycle completion pulse).
REQ-007 SHALL have ports mem_req out 1, mem_we out 1 (1 = store), mem_addr out ADDR_W, mem_wdata out DATA_W, mem_ack in 1, mem_rdata in DATA_W.

Function
REQ-008 SHALL use instruction fields op=[15:12], ra=[11:8], rb=[7:4], rd=[3:0], with 16 registers R0..R15 of DATA_W bits.
REQ-009 SHALL implement these states:
  - LOAD
  - IDLE
  - FETCH
  - DECODE
  - EXEC
  - MEM
  - MEMWAIT
  - WB
  - DONE
REQ-010 SHALL leave reset in LOAD with prog_ready=1; prog_ready SHALL also be 1 in IDLE, and 0 in every other state.
REQ-011 SHALL write prog_data to imem[wptr] when prog_valid&prog_ready, then increment wptr; a prog_valid in IDLE SHALL restart loading at wptr=0 and enter LOAD.
REQ-012 SHALL end loading when an accepted word has prog_last=1 or wptr=IMEM_DEPTH-1. It SHALL then set prog_len=wptr+1 and go to IDLE; any extra words are not accepted.
REQ-013 SHALL ignore start in LOAD; in IDLE, start SHALL set PC=0, load R15 with core_id (zero-extended), set busy=1, and go to FETCH.
REQ-014 SHALL sequence non-memory instructions FETCH->DECODE->EXEC->MEM->WB->FETCH, i.e. 5 cycles each.
REQ-015 SHALL apply these ALU rules, all results truncated to DATA_W:
  - 1 add, 2 sub: modulo arithmetic.
  - 3 mul: low DATA_W bits.
  - 4 div: unsigned; divisor 0 gives all-ones.
  - 5 cmpge: unsigned, result 1/0.
  - 6 shr, 7 shl: shift count = Rb; a count ≥DATA_W gives 0.
  - 8 and, 9 or, 10 xor.
  - Each writes Rd in WB.
REQ-016 SHALL treat op 12 (LI) as Rd <= IR[11:4] zero-extended or truncated to DATA_W.
REQ-017 SHALL compute the address for op 11 (LD) and op 13 (ST) as {Ra,Rb} truncated or zero-extended to ADDR_W. ST data SHALL be Rd, read in DECODE.
REQ-018 SHALL, in MEM for LD/ST, drive mem_req=1, mem_we, mem_addr and mem_wdata, and enter MEMWAIT. These outputs SHALL stay stable until the cycle mem_ack=1 is sampled, and mem_req SHALL drop on the next edge.
REQ-019 SHALL ignore mem_ack whenever mem_req=0; LD SHALL capture mem_rdata on ack and write Rd in WB, and ST SHALL write nothing.
REQ-020 SHALL treat op 14 (BNZ) as: if Ra≠0, next PC = IR[7:0] modulo IMEM_DEPTH; otherwise PC+1. BNZ SHALL write no register.
REQ-021 SHALL treat op 0 as NOP and op 15 as HALT.
REQ-022 SHALL enter DONE after WB when any of these holds:
  - the instruction was HALT;
  - PC=prog_len-1 and no branch was taken;
  - a branch target is ≥prog_len.
REQ-023 SHALL, in DONE, assert done=1 for exactly one cycle and busy=0, then return to IDLE. Registers and program SHALL be retained, so a new start reruns the program.
REQ-024 SHALL keep R0..R14 unchanged across start; only R15 is reloaded.

Reset
REQ-025 SHALL, on reset in any state (including during MEMWAIT with mem_req=1), go to LOAD and set:
  - prog_ready=1, busy=0, done=0;
  - mem_req=0, mem_we=0, mem_addr=0, mem_wdata=0;
  - PC=0, wptr=0, prog_len=0;
  - all registers = 0.
REQ-026 SHALL not reset imem contents, and SHALL require a program reload after reset.

Structure
REQ-027 SHALL place opcode constants, the state enumeration and the field-position constants in shared package gpu_core_pkg.
REQ-028 SHALL instantiate one combinational sub-module gpu_alu (op, a, b -> result, DATA_W parameter) for REQ-015.

Verification
REQ-029 SHALL cover the load-and-arithmetic scenario with DATA_W=8:
  - Stimulus: load [LI R1,200; LI R2,100; ADD R3=R1+R2; HALT], then start.
  - Response: R3=44, done pulses once, busy high for exactly 4×5+1 cycles.
REQ-030 SHALL cover the divide-by-zero and shift-overflow scenario:
  - Stimulus: DIV of 7 by 0, then SHL 1 by 9 (DATA_W=8).
  - Response: results 0xFF and 0x00.
REQ-031 SHALL cover the load/store handshake scenario:
  - Stimulus: ST R5=0x5A to {R1=0x3,R2=0x21}, then LD back, with mem_ack delayed 3 cycles each.
  - Response: mem_addr=0x321 held stable, mem_we 1 then 0, loaded register=0x5A, no ack accepted while mem_req=0.
REQ-032 SHALL cover the branch-loop scenario:
  - Stimulus: a loop decrementing R1 from 3 with BNZ to 0.
  - Response: body executes 3 times, then the core falls through to DONE.
  - Stimulus: a BNZ target of 9 with prog_len=4.
  - Response: immediate DONE.
REQ-033 SHALL cover the full-depth load scenario:
  - Stimulus: offer 20 words with IMEM_DEPTH=16 and no prog_last.
  - Response: exactly 16 accepted, prog_len=16, prog_ready stays 1 in IDLE.
REQ-034 SHALL cover the reset-during-MEMWAIT scenario:
  - Stimulus: assert reset while in MEMWAIT.
  - Response: next cycle mem_req=0, busy=0, state LOAD, start ignored until reload.
